// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock FIFO on an internal RAM with a two-stage registered read.
// Status flags are decoded from the registered pointers. Overflow and underflow are
// registered pulses that appear the cycle after the rejected request.
// Optional feature macro: FIFO_PARITY_EN adds an even-parity bit per stored word and
// raises rd_parity_err alongside rd_valid when the stored parity does not match.
module sync_fifo_ram #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 1024,
  parameter int ADDR      = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_datain,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dataout,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow,
  output logic             rd_parity_err
);

`ifdef FIFO_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [ADDR:0] PTR_INC = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0] AF_LVL  = (ADDR+1)'(AF_THRESH);
  localparam logic [ADDR:0] AE_LVL  = (ADDR+1)'(AE_THRESH);

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] mem_q;
  logic [MW-1:0] wr_word;
  logic [ADDR:0] wr_ptr;
  logic [ADDR:0] rd_ptr;
  logic          v1;
  logic          wr_acc;
  logic          rd_acc;

  // The MSB of each pointer is a wrap bit; it separates full from empty when the low bits match.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR] != rd_ptr[ADDR]) &&
                        (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign wr_acc       = wr_en && !full;
  assign rd_acc       = rd_en && !empty;

`ifdef FIFO_PARITY_EN
  assign wr_word = {^wr_datain, wr_datain};
`else
  assign wr_word = wr_datain;
`endif

  // RAM write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (reset_n && wr_acc) begin
      mem[wr_ptr[ADDR-1:0]] <= wr_word;
    end
  end

  // Pointer advance on accepted accesses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_INC;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  // Read stage 1: registered RAM read of the word at the current read pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1 <= 1'b0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) mem_q <= mem[rd_ptr[ADDR-1:0]];
    end
  end

  // Read stage 2: output register, holds the last popped word while idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid   <= 1'b0;
      rd_dataout <= '0;
    end else begin
      rd_valid <= v1;
      if (v1) rd_dataout <= mem_q[WIDTH-1:0];
    end
  end

  // Error strobes for requests that hit a full or empty FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

`ifdef FIFO_PARITY_EN
  // Parity check on the word moving into the output register, aligned with rd_valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_parity_err <= 1'b0;
    end else begin
      rd_parity_err <= v1 && ((^mem_q[WIDTH-1:0]) != mem_q[WIDTH]);
    end
  end
`else
  assign rd_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ram.sv
// tb_sync_fifo_ram: directed scenarios plus randomized traffic for sync_fifo_ram,
// checked every cycle against a queue-based reference model.
module tb_sync_fifo_ram;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int AFT = 12;
  localparam int AET = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_datain = '0;
  logic         rd_en = 1'b0;
  logic [W-1:0] rd_dataout;
  logic         rd_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [4:0]   count;
  logic         overflow;
  logic         underflow;
  logic         rd_parity_err;

  sync_fifo_ram #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AFT), .AE_THRESH(AET)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_en         (wr_en),
    .wr_datain     (wr_datain),
    .rd_en         (rd_en),
    .rd_dataout    (rd_dataout),
    .rd_valid      (rd_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .rd_parity_err (rd_parity_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] q[$];
  bit           qe[$];
  bit           pv;
  logic [W-1:0] pd;
  bit           pe;
  bit           exp_valid, exp_ovf, exp_udf, exp_perr;
  logic [W-1:0] exp_data;
  int           wr_total;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    check_eq("count",         32'(count),         32'(sz));
    check_eq("empty",         32'(empty),         32'(sz == 0));
    check_eq("full",          32'(full),          32'(sz == D));
    check_eq("almost_full",   32'(almost_full),   32'(sz >= AFT));
    check_eq("almost_empty",  32'(almost_empty),  32'(sz <= AET));
    check_eq("overflow",      32'(overflow),      32'(exp_ovf));
    check_eq("underflow",     32'(underflow),     32'(exp_udf));
    check_eq("rd_valid",      32'(rd_valid),      32'(exp_valid));
    check_eq("rd_dataout",    32'(rd_dataout),    32'(exp_data));
    check_eq("rd_parity_err", 32'(rd_parity_err), 32'(exp_perr));
  endtask

  // One clock: apply inputs, advance the model at the edge, check just after it.
  task automatic cyc(input bit wr, input logic [W-1:0] d, input bit rd, input bit rst_n);
    bit full_b, empty_b;
    wr_en = wr; wr_datain = d; rd_en = rd; reset_n = rst_n;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); qe.delete();
      pv = 0; pe = 0; pd = '0;
      exp_valid = 0; exp_ovf = 0; exp_udf = 0; exp_perr = 0; exp_data = '0;
      wr_total = 0;
    end else begin
      full_b  = (q.size() == D);
      empty_b = (q.size() == 0);
      exp_valid = pv;
      exp_perr  = pv && pe;
      if (pv) exp_data = pd;
      pv = 0; pe = 0;
      if (rd && !empty_b) begin
        pd = q.pop_front();
        pe = qe.pop_front();
        pv = 1;
      end
      if (wr && !full_b) begin
        q.push_back(d);
        qe.push_back(1'b0);
        wr_total++;
      end
      exp_ovf = wr && full_b;
      exp_udf = rd && empty_b;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2; i++) cyc(0, '0, 1, 1);
    idle(2);
  endtask

  int wr_pct;
  int rd_pct;
  logic [W-1:0] dval;

  initial begin
    // reset
    cyc(0, '0, 0, 0);
    cyc(1, 8'h77, 1, 0);
    idle(2);

    // order and read latency
    for (int i = 1; i <= 4; i++) cyc(1, W'(i), 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 1);
    idle(3);

    // fill, overflow, readback
    for (int i = 0; i < 16; i++) cyc(1, W'(8'h10 + i), 0, 1);
    cyc(1, 8'hAA, 0, 1);
    idle(1);
    drain();

    // simultaneous access at mid level, at empty, at full
    for (int i = 0; i < 8; i++) cyc(1, W'(8'h20 + i), 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, W'(8'h30 + i), 1, 1);
    drain();
    cyc(1, 8'h41, 1, 1);
    idle(1);
    drain();
    for (int i = 0; i < 16; i++) cyc(1, W'(8'h50 + i), 0, 1);
    cyc(1, 8'hBB, 1, 1);
    idle(1);
    drain();

    // pointer wrap and thresholds
    dval = 8'h80;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin cyc(1, dval, 0, 1); dval++; end
      for (int i = 0; i < 12; i++) cyc(0, '0, 1, 1);
      idle(2);
    end

    // reset with reads in flight
    for (int i = 0; i < 5; i++) cyc(1, W'(8'hC0 + i), 0, 1);
    cyc(0, '0, 1, 1);
    cyc(0, '0, 1, 0);
    idle(4);

`ifdef FIFO_PARITY_EN
    begin
      int slot;
      slot = wr_total % D;
      cyc(1, 8'h5A, 0, 1);
      dut.mem[slot][0] = ~dut.mem[slot][0];
      q[q.size()-1]  = q[q.size()-1] ^ 8'h01;
      qe[qe.size()-1] = 1'b1;
      cyc(1, 8'h33, 0, 1);
      drain();
    end
`endif

    // randomized traffic with shifting bias and occasional reset
    for (int ph = 0; ph < 8; ph++) begin
      case (ph % 4)
        0: begin wr_pct = 75; rd_pct = 30; end
        1: begin wr_pct = 30; rd_pct = 75; end
        2: begin wr_pct = 55; rd_pct = 55; end
        default: begin wr_pct = 95; rd_pct = 10; end
      endcase
      for (int i = 0; i < 250; i++) begin
        cyc($urandom_range(0, 99) < wr_pct, W'($urandom_range(0, 255)),
            $urandom_range(0, 99) < rd_pct, $urandom_range(0, 199) != 0);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
